sd_block_writer: RTL and testbench
==================================

# sd_block_writer

SPI-mode SD single-block writer: the write-direction partner of the SD block reader. After the card has been initialised, a `start` pulse issues CMD24 for `address`, streams one data block popped from the shared byte FIFO, and checks the card's data-response token. It then waits out card busy and reports `done` with an error flag. It drives the same CS/SCLK/MOSI/MISO pins; an external arbiter muxes them with the reader.

## Interface
- `CLK_DIV`, 2: system clocks per SCLK half-period; must be ≥1.
- `BLOCK_BYTES`, 512: number of data bytes per block.
- `NCR_MAX`, 8: maximum number of 0xFF bytes clocked while waiting for R1.
- `BUSY_MAX`, 16'hFFFF: maximum number of bytes polled while the card is busy.

- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; ignored while `busy`=1.
- `address`  in  32  CMD24 argument, sampled when `start` is accepted.
- `fifo_data_out`  in  8  FIFO head byte (first-word-fall-through).
- `fifo_empty`  in  1  FIFO has no data.
- `fifo_pop`  out  1  one-cycle pop; the head byte is consumed in the same cycle.
- `MISO`  in  1  card data out.
- `CS`  out  1  chip select, active-low.
- `SCLK`  out  1  SPI clock, mode 0, idles low.
- `MOSI`  out  1  card data in, idles high.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at the end of a transaction, on success or error.
- `error`  out  1  high if the last transaction failed; held until the next accepted `start`.
- `status`  out  8  last R1 byte or data-response byte that decided the outcome.

## Operation
- **Byte engine:** 8-bit shift register, MSB first.
  - MOSI is set up while SCLK is low.
  - MISO is sampled on the SCLK rising edge and shifted into the receive register.
  - One byte takes 16·CLK_DIV clocks. The FSM advances only at byte boundaries.
- **FSM states:**
  - IDLE: CS=1. Accepted `start` → CMD.
  - CMD: 6 bytes: 0x58, address[31:24], [23:16], [15:8], [7:0], 0xFF (dummy CRC).
  - R1: transmit 0xFF and receive. The first received byte with bit7=0 is R1.
    - R1=0x00 → GAP.
    - R1≠0x00 → ERR, status=R1.
    - NCR_MAX bytes without R1 → ERR, status=0xFF.
  - GAP: one 0xFF byte.
  - TOKEN: one byte 0xFE.
  - DATA: BLOCK_BYTES bytes. Each byte is loaded from `fifo_data_out` with `fifo_pop`=1 in the load cycle.
    - If `fifo_empty`=1 at a byte boundary: stall with SCLK low, CS low, MOSI high, and no pop.
    - Resume on the first cycle with `fifo_empty`=0.
  - CRC: 2 bytes of 0xFF.
  - DRESP: transmit 0xFF and store the received byte in `status`.
    - (byte & 0x1F)==0x05 → BUSYW.
    - Anything else → ERR.
  - BUSYW: transmit 0xFF until a received byte equals 0xFF → FIN.
    - BUSY_MAX bytes without 0xFF → ERR, status unchanged.
  - FIN: CS=1, then one 0xFF byte (8 SCLKs) with CS high. Pulse `done`, error=0, → IDLE.
  - ERR: CS=1, then one 0xFF byte with CS high. Pulse `done`, error=1, → IDLE. No further FIFO pops.
- Exactly BLOCK_BYTES pops per successful transaction; zero pops if the transaction fails before DATA.
- `start` while `busy` has no effect and is not queued.
- `address` changes after acceptance have no effect.

## Timing
- **Reset values:** CS=1, SCLK=0, MOSI=1, busy=0, done=0, error=0, fifo_pop=0, status=0x00.
- **Reset mid-transaction:** outputs take their reset values immediately (asynchronous) and remain there until `reset` is released. After release the block is in IDLE with no pending request.
- **Start:** `start` sampled at edge N → busy=1 and CS=0 from N+1. MOSI carries the bit7 of 0x58 from N+1. The first SCLK rise occurs at N+1+CLK_DIV.
- **Bit timing:** SCLK high for CLK_DIV clocks, low for CLK_DIV clocks. MOSI changes only on the clock where SCLK falls, or at the byte load.
- **Done:** `done` is high for exactly one cycle, on the cycle after the last SCLK fall of the FIN/ERR byte. busy=0 in that same cycle.
- **Status/error:** both are updated no later than the `done` cycle. `error` is cleared on the cycle after the next accepted `start`.
- **Minimum transaction** (R1 in first byte, no busy, no stalls): (6+1+1+1+512+2+1+1+1)·16·CLK_DIV clocks plus 1.

## Test plan
- **Nominal write:** card model replies R1=0x00 after 1 byte, data response 0xE5, busy 0x00×3 then 0xFF. FIFO holds 512 bytes i&0xFF; address=0x0000_0200.
  - MOSI: 58 00 00 02 00 FF, FF (R1), FF, FE, 00..FF twice, FF FF.
  - 512 pops, one `done`, error=0, status=0xE5.
- **R1 timeout:** MISO held at 1 → after 8 R1 bytes: CS=1, done, error=1, status=0xFF, 0 pops.
- **R1 rejected:** R1=0x04 → error=1, status=0x04, no 0xFE token on MOSI.
- **CRC reject:** data response 0x0B → error=1, status=0x0B, 512 pops, no busy polling.
- **Underflow stall:** `fifo_empty`=1 for 100 cycles at byte 100 → SCLK frozen low and CS low during the stall. Byte stream intact, 512 pops, success.
- **Reset mid-DATA:** assert `reset` at byte 200 → CS=1, SCLK=0, MOSI=1, busy=0 at once. After release, a new `start` completes the nominal case.

Source files
------------

// File: rtl/sd_block_writer.sv
// sd_block_writer: SPI-mode SD single-block write (CMD24) engine.
// Streams one FIFO block to the card and reports the data-response outcome.
module sd_block_writer #(
    parameter int          CLK_DIV     = 2,
    parameter int          BLOCK_BYTES = 512,
    parameter int          NCR_MAX     = 8,
    parameter logic [15:0] BUSY_MAX    = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] address,
    input  logic [7:0]  fifo_data_out,
    input  logic        fifo_empty,
    output logic        fifo_pop,
    input  logic        MISO,
    output logic        CS,
    output logic        SCLK,
    output logic        MOSI,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [15:0]   NCR_LAST  = 16'(NCR_MAX - 1);
    localparam logic [15:0]   DATA_LAST = 16'(BLOCK_BYTES - 1);
    localparam logic [15:0]   BUSY_LAST = BUSY_MAX - 16'd1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_R1,
        S_GAP,
        S_TOKEN,
        S_DATA,
        S_CRC,
        S_DRESP,
        S_BUSYW,
        S_FIN,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    status_q, status_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          error_q, error_d;
    logic          done_q, done_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          run_q, run_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;

    logic       tick;
    logic       rise;
    logic       fall;
    logic       byte_done;
    logic       load;
    logic [7:0] load_byte;
    logic [7:0] cmd_next;

    always_comb begin
        case (cnt_q[2:0])
            3'd0:    cmd_next = addr_q[31:24];
            3'd1:    cmd_next = addr_q[23:16];
            3'd2:    cmd_next = addr_q[15:8];
            3'd3:    cmd_next = addr_q[7:0];
            default: cmd_next = 8'hFF;
        endcase
    end

    always_comb begin
        tick      = (div_q == DIV_LAST);
        rise      = run_q & tick & ~sclk_q;
        fall      = run_q & tick & sclk_q;
        byte_done = fall & (bit_q == 3'd7);

        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        status_d  = status_q;
        error_d   = error_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;
        load      = 1'b0;
        load_byte = 8'hFF;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CMD;
                    addr_d    = address;
                    error_d   = 1'b0;
                    cnt_d     = '0;
                    load      = 1'b1;
                    load_byte = 8'h58;
                end
            end
            S_CMD: begin
                if (byte_done) begin
                    load = 1'b1;
                    if (cnt_q == 16'd5) begin
                        state_d = S_R1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d     = cnt_q + 16'd1;
                        load_byte = cmd_next;
                    end
                end
            end
            S_R1: begin
                if (byte_done) begin
                    load = 1'b1;
                    if (!rx_q[7]) begin
                        if (rx_q == 8'h00) begin
                            state_d = S_GAP;
                        end else begin
                            state_d  = S_ERR;
                            status_d = rx_q;
                        end
                    end else if (cnt_q == NCR_LAST) begin
                        state_d  = S_ERR;
                        status_d = 8'hFF;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_GAP: begin
                if (byte_done) begin
                    state_d   = S_TOKEN;
                    load      = 1'b1;
                    load_byte = 8'hFE;
                end
            end
            S_TOKEN: begin
                if (byte_done) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    load      = ~fifo_empty;
                    fifo_pop  = ~fifo_empty;
                    load_byte = fifo_data_out;
                end
            end
            S_DATA: begin
                // an empty FIFO at a boundary parks the engine until data shows up
                if (byte_done) begin
                    if (cnt_q == DATA_LAST) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + 16'd1;
                        load      = ~fifo_empty;
                        fifo_pop  = ~fifo_empty;
                        load_byte = fifo_data_out;
                    end
                end else if (!run_q && !fifo_empty) begin
                    load      = 1'b1;
                    fifo_pop  = 1'b1;
                    load_byte = fifo_data_out;
                end
            end
            S_CRC: begin
                if (byte_done) begin
                    load = 1'b1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_DRESP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_DRESP: begin
                if (byte_done) begin
                    load     = 1'b1;
                    status_d = rx_q;
                    if (rx_q[4:0] == 5'b00101) begin
                        state_d = S_BUSYW;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_BUSYW: begin
                if (byte_done) begin
                    load = 1'b1;
                    if (rx_q == 8'hFF) begin
                        state_d = S_FIN;
                    end else if (cnt_q == BUSY_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_FIN: begin
                if (byte_done) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b0;
                end
            end
            S_ERR: begin
                if (byte_done) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        div_d  = (run_q && !tick) ? div_q + DW'(1) : '0;
        sclk_d = (run_q && tick) ? ~sclk_q : sclk_q;
        bit_d  = fall ? bit_q + 3'd1 : bit_q;
        tx_d   = fall ? {tx_q[6:0], 1'b1} : tx_q;
        rx_d   = rise ? {rx_q[6:0], MISO} : rx_q;
        run_d  = byte_done ? 1'b0 : run_q;
        if (load) begin
            tx_d   = load_byte;
            div_d  = '0;
            sclk_d = 1'b0;
            bit_d  = '0;
            run_d  = 1'b1;
        end

        cs_d = (state_d == S_IDLE) || (state_d == S_FIN) || (state_d == S_ERR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            status_q <= '0;
            tx_q     <= 8'hFF;
            rx_q     <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            run_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            status_q <= status_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            error_q  <= error_d;
            done_q   <= done_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            run_q    <= run_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
        end
    end

    assign CS     = cs_q;
    assign SCLK   = sclk_q;
    assign MOSI   = tx_q[7];
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign error  = error_q;
    assign status = status_q;

endmodule

// File: tb/tb_sd_block_writer.sv
// tb_sd_block_writer: directed bench for the SD single-block writer.
// A small card model replays scripted MISO bytes and records MOSI bytes.
module tb_sd_block_writer;
    localparam int CD    = 2;
    localparam int BB    = 512;
    localparam int BC    = 16 * CD;
    localparam int LIMIT = 20000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] address = '0;
    logic [7:0]  fifo_data_out;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        MISO = 1'b1;
    logic        CS;
    logic        SCLK;
    logic        MOSI;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  status;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int done_cnt = 0;

    always #5 clock = ~clock;

    sd_block_writer #(
        .CLK_DIV    (CD),
        .BLOCK_BYTES(BB),
        .NCR_MAX    (8),
        .BUSY_MAX   (16'hFFFF)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .address      (address),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .fifo_pop     (fifo_pop),
        .MISO         (MISO),
        .CS           (CS),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .status       (status)
    );

    always @(posedge clock) cyc++;
    always @(negedge clock) if (done === 1'b1) done_cnt++;

    // FIFO holding bytes i & 0xFF, head at rd_ptr
    int   rd_ptr = 0;
    logic fifo_clr = 1'b0;
    logic stall = 1'b0;
    always @(posedge clock) begin
        if (fifo_clr) rd_ptr <= 0;
        else if (fifo_pop === 1'b1) rd_ptr <= rd_ptr + 1;
    end
    assign fifo_data_out = rd_ptr[7:0];
    assign fifo_empty    = stall | (rd_ptr >= BB);

    // card model
    logic       r1_on = 1'b1;
    logic [7:0] r1_val = 8'h00;
    logic [7:0] dresp_val = 8'hE5;
    int         busy_n = 3;
    logic [7:0] seen [0:1023];
    int         nbytes = 0;

    function automatic logic [7:0] resp(input int k);
        if (k == 6 && r1_on) return r1_val;
        if (k == 523) return dresp_val;
        if (k > 523 && k < 524 + busy_n) return 8'h00;
        return 8'hFF;
    endfunction

    initial begin
        logic       cs_prev;
        logic       sclk_prev;
        logic [7:0] cur;
        logic [7:0] rxsh;
        int         bitc;
        int         kidx;
        cs_prev = 1'b1;
        sclk_prev = 1'b0;
        cur = 8'hFF;
        rxsh = 8'h00;
        bitc = 0;
        kidx = 0;
        forever begin
            @(CS or SCLK);
            if (CS !== 1'b0) begin
                MISO = 1'b1;
            end else if (cs_prev === 1'b1) begin
                bitc = 0;
                kidx = 0;
                nbytes = 0;
                cur = resp(0);
                MISO = cur[7];
            end else if (SCLK === 1'b1 && sclk_prev === 1'b0) begin
                rxsh = {rxsh[6:0], MOSI};
                bitc++;
                if (bitc == 8) begin
                    if (nbytes < 1024) seen[nbytes] = rxsh;
                    nbytes++;
                    kidx++;
                    bitc = 0;
                end
            end else if (SCLK === 1'b0 && sclk_prev === 1'b1) begin
                if (bitc == 0) cur = resp(kidx);
                MISO = cur[7-bitc];
            end
            cs_prev = CS;
            sclk_prev = SCLK;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k, input logic [31:0] a);
        int d;
        d = k - 9;
        if (k == 0) return 8'h58;
        if (k == 1) return a[31:24];
        if (k == 2) return a[23:16];
        if (k == 3) return a[15:8];
        if (k == 4) return a[7:0];
        if (k == 8) return 8'hFE;
        if (k >= 9 && k < 9 + BB) return d[7:0];
        return 8'hFF;
    endfunction

    task automatic stream_errs(input logic [31:0] a, output int errs);
        errs = 0;
        for (int k = 0; k < nbytes && k < 1024; k++)
            if (seen[k] !== exp_byte(k, a)) errs++;
    endtask

    task automatic set_card(input logic on, input logic [7:0] r1,
                            input logic [7:0] dr, input int bn);
        r1_on = on;
        r1_val = r1;
        dresp_val = dr;
        busy_n = bn;
    endtask

    task automatic clr_fifo();
        fifo_clr = 1'b1;
        @(posedge clock);
        #1 fifo_clr = 1'b0;
    endtask

    task automatic start_txn(input logic [31:0] a);
        @(posedge clock);
        #1;
        address = a;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        address = 32'hFFFF_FFFF;
        t0 = cyc;
    endtask

    task automatic wait_done(output int dur, output bit ok);
        ok = 1'b0;
        dur = 0;
        for (int i = 0; i < LIMIT; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                dur = cyc - t0 + 1;
                break;
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int         dur;
        int         d0;
        int         errs;
        int         fe;
        int         sbad;
        int         sp;
        bit         ok;
        logic [7:0] pat;

        // reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst_cs", CS, 1);
        chk("rst_sclk", SCLK, 0);
        chk("rst_mosi", MOSI, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_pop", fifo_pop, 0);
        chk("rst_status", status, 0);
        @(posedge clock);
        #1 reset = 1'b1;

        // nominal write, plus an ignored start while busy
        set_card(1'b1, 8'h00, 8'hE5, 3);
        clr_fifo();
        d0 = done_cnt;
        start_txn(32'h0000_0200);
        chk("start_busy", busy, 1);
        chk("start_cs", CS, 0);
        chk("start_mosi", MOSI, 0);
        pat = '0;
        for (int i = 0; i <= CD; i++) begin
            pat[i] = SCLK;
            @(posedge clock);
            #1;
        end
        chk("start_sclk", pat, 8'(1 << CD));
        address = 32'hDEAD_BEEF;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(dur, ok);
        chk("nom_done", ok, 1);
        chk("nom_len", dur, 529 * BC + 1);
        chk("nom_error", error, 0);
        chk("nom_status", status, 8'hE5);
        chk("nom_cs_done", CS, 1);
        chk("nom_busy_done", busy, 0);
        repeat (4) @(posedge clock);
        #1;
        chk("nom_done_cnt", done_cnt - d0, 1);
        chk("nom_pops", rd_ptr, BB);
        stream_errs(32'h0000_0200, errs);
        chk("nom_stream", errs, 0);
        chk("nom_nbytes", nbytes, 528);
        repeat (40) @(posedge clock);
        #1 chk("nom_noqueue", busy, 0);

        // R1 timeout
        set_card(1'b0, 8'h00, 8'hE5, 0);
        clr_fifo();
        d0 = done_cnt;
        start_txn(32'h0000_1000);
        wait_done(dur, ok);
        chk("to_done", ok, 1);
        chk("to_len", dur, 15 * BC + 1);
        chk("to_error", error, 1);
        chk("to_status", status, 8'hFF);
        chk("to_cs", CS, 1);
        repeat (4) @(posedge clock);
        #1;
        chk("to_done_cnt", done_cnt - d0, 1);
        chk("to_pops", rd_ptr, 0);
        chk("to_nbytes", nbytes, 14);

        // R1 rejected
        set_card(1'b1, 8'h04, 8'hE5, 0);
        clr_fifo();
        start_txn(32'h0000_1000);
        wait_done(dur, ok);
        chk("rej_done", ok, 1);
        chk("rej_len", dur, 8 * BC + 1);
        chk("rej_error", error, 1);
        chk("rej_status", status, 8'h04);
        repeat (4) @(posedge clock);
        #1;
        fe = 0;
        for (int k = 0; k < nbytes && k < 1024; k++)
            if (seen[k] === 8'hFE) fe++;
        chk("rej_no_token", fe, 0);
        chk("rej_pops", rd_ptr, 0);
        chk("rej_nbytes", nbytes, 7);

        // data response CRC reject
        set_card(1'b1, 8'h00, 8'h0B, 3);
        clr_fifo();
        start_txn(32'h0012_3456);
        wait_done(dur, ok);
        chk("crc_done", ok, 1);
        chk("crc_len", dur, 525 * BC + 1);
        chk("crc_error", error, 1);
        chk("crc_status", status, 8'h0B);
        repeat (4) @(posedge clock);
        #1;
        chk("crc_pops", rd_ptr, BB);
        chk("crc_nbytes", nbytes, 524);
        repeat (20) @(posedge clock);
        #1 chk("err_hold", error, 1);

        // underflow stall at byte 100
        set_card(1'b1, 8'h00, 8'hE5, 3);
        clr_fifo();
        start_txn(32'hA5C3_0F01);
        chk("err_clr", error, 0);
        sbad = 0;
        sp = 0;
        fork
            wait_done(dur, ok);
            begin
                for (int i = 0; i < LIMIT && rd_ptr < 100; i++) begin
                    @(posedge clock);
                    #1;
                end
                stall = 1'b1;
                repeat (BC + 2) begin
                    @(posedge clock);
                    #1;
                end
                repeat (100 - BC - 2) begin
                    @(posedge clock);
                    #1;
                    if (SCLK !== 1'b0 || CS !== 1'b0 || MOSI !== 1'b1 ||
                        fifo_pop !== 1'b0) sbad++;
                end
                sp = rd_ptr;
                stall = 1'b0;
            end
        join
        chk("stl_done", ok, 1);
        chk("stl_error", error, 0);
        chk("stl_status", status, 8'hE5);
        chk("stl_frozen", sbad, 0);
        chk("stl_ptr", sp, 100);
        repeat (4) @(posedge clock);
        #1;
        chk("stl_pops", rd_ptr, BB);
        stream_errs(32'hA5C3_0F01, errs);
        chk("stl_stream", errs, 0);
        chk("stl_nbytes", nbytes, 528);

        // reset during DATA, then a clean nominal write
        clr_fifo();
        start_txn(32'h0000_0200);
        for (int i = 0; i < LIMIT && rd_ptr < 200; i++) begin
            @(posedge clock);
            #1;
        end
        chk("mid_reach", rd_ptr >= 200, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_pins", {CS, SCLK, MOSI, busy, fifo_pop, done}, 6'b101000);
        repeat (3) @(posedge clock);
        #1;
        chk("mid_hold", {CS, SCLK, MOSI, busy, fifo_pop, done}, 6'b101000);
        chk("mid_status", status, 0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 chk("mid_idle", {busy, CS}, 2'b01);
        clr_fifo();
        start_txn(32'h0000_0200);
        wait_done(dur, ok);
        chk("re_done", ok, 1);
        chk("re_len", dur, 529 * BC + 1);
        chk("re_error", error, 0);
        chk("re_status", status, 8'hE5);
        repeat (4) @(posedge clock);
        #1;
        chk("re_pops", rd_ptr, BB);
        stream_errs(32'h0000_0200, errs);
        chk("re_stream", errs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
